// File: rtl/fios_pkg.sv
// fios_pkg: shared types and schedule helpers for the
// folded FIOS control sequencer.
package fios_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    PUSH,
    DONE
  } fios_state_e;

  function automatic int gap_bits(
    input int pe_delay,
    input int loop_delay,
    input int res_offset,
    input int s_max
  );
    int m;
    m = pe_delay + loop_delay + 1;
    if (res_offset > m) m = res_offset;
    if (s_max > m) m = s_max;
    return $clog2(m + 1);
  endfunction

  // Gap timer width of the default configuration.
  localparam int GAP_W = gap_bits(6, 0, 10, 8);

  function automatic int iter_start_offset(
    input int i,
    input int pe_nb,
    input int pe_delay,
    input int loop_delay
  );
    return i * pe_delay + (i / pe_nb) * (loop_delay + 1);
  endfunction

endpackage

// File: rtl/fios_fold_seq_if.sv
// fios_fold_seq_if: start handshake and PE-array
// control strobes of the folded FIOS sequencer.
interface fios_fold_seq_if #(
  parameter int S_MAX = 8,
  parameter int PE_NB = 3
);
  localparam int SW = $clog2(S_MAX + 1);

  logic             start_i;
  logic [SW-1:0]    s_i;
  logic             start_ready_o;
  logic             busy_o;
  logic [PE_NB-1:0] pe_start_o;
  logic             fb_sel_o;
  logic             a_shift_o;
  logic             b_fetch_o;
  logic             p_fetch_o;
  logic             res_push_o;
  logic             done_o;

  modport master (
    output start_i, s_i,
    input  start_ready_o, busy_o, pe_start_o,
    input  fb_sel_o, a_shift_o, b_fetch_o,
    input  p_fetch_o, res_push_o, done_o
  );

  modport slave (
    input  start_i, s_i,
    output start_ready_o, busy_o, pe_start_o,
    output fb_sel_o, a_shift_o, b_fetch_o,
    output p_fetch_o, res_push_o, done_o
  );
endinterface

// File: rtl/fios_pend_slot.sv
// fios_pend_slot: one queued start request with its
// word count; ready is high while the slot is empty.
module fios_pend_slot #(
  parameter int SW = 4
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          load,
  input  logic [SW-1:0] s_new,
  input  logic          pop,
  output logic          ready,
  output logic [SW-1:0] s_held
);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ready  <= 1'b1;
      s_held <= '0;
    end else if (load) begin
      ready  <= 1'b0;
      s_held <= s_new;
    end else if (pop) begin
      ready  <= 1'b1;
    end
  end

endmodule

// File: rtl/fios_fold_seq.sv
// fios_fold_seq: schedules s outer-loop iterations over
// a ring of PE_NB processing elements, one op queued.
module fios_fold_seq
  import fios_pkg::*;
#(
  parameter int S_MAX      = 8,
  parameter int PE_NB      = 3,
  parameter int PE_DELAY   = 6,
  parameter int LOOP_DELAY = 0,
  parameter int RES_OFFSET = 10
) (
  input logic            clock_i,
  input logic            reset_i,
  fios_fold_seq_if.slave bus
);

  localparam int SW = $clog2(S_MAX + 1);
  localparam int IW = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int PW = (PE_NB > 1) ? $clog2(PE_NB) : 1;
  localparam int GW =
    gap_bits(PE_DELAY, LOOP_DELAY, RES_OFFSET, S_MAX);

  localparam int STEP_GAP = PE_DELAY - 1;
  localparam int WRAP_GAP =
    iter_start_offset(PE_NB, PE_NB, PE_DELAY, LOOP_DELAY)
    - iter_start_offset(PE_NB - 1, PE_NB, PE_DELAY,
                        LOOP_DELAY) - 1;
  localparam int DRAIN_GAP = RES_OFFSET - 2;
  localparam logic [PE_NB-1:0] PE_ONE = PE_NB'(1);

  if (PE_NB < 1 || PE_NB > S_MAX) begin : g_chk_pe
    $error("fios_fold_seq: PE_NB must be 1..S_MAX");
  end
  if (RES_OFFSET < 1) begin : g_chk_res
    $error("fios_fold_seq: RES_OFFSET must be >= 1");
  end
  if (PE_DELAY < 1) begin : g_chk_dly
    $error("fios_fold_seq: PE_DELAY must be >= 1");
  end

  fios_state_e      state_q, state_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [SW-1:0]    cur_s_q, cur_s_d;
  logic [SW-1:0]    bcnt_q, bcnt_d;
  logic [PE_NB-1:0] pe_q, pe_d;
  logic             busy_q, fb_q, ash_q;
  logic             bf_q, pf_q, push_q, done_q;
  logic             fb_d, ash_d, issue_d;

  logic          pend_ready;
  logic [SW-1:0] held_s;
  logic          s_ok, direct, load, pop, launch;
  logic [SW-1:0] launch_s;
  logic          issue_now, last_iter, wrap;

  assign s_ok   = bus.start_i && (bus.s_i != '0);
  assign direct = s_ok && ((state_q == IDLE) ||
                  ((state_q == DONE) && pend_ready));
  assign load   = s_ok && pend_ready && !direct;
  assign pop    = (state_q == DONE) && !pend_ready;
  assign launch = direct || pop;
  assign launch_s = pop ? held_s : bus.s_i;

  assign issue_now = (state_q == ISSUE) && (gap_q == '0);
  assign last_iter = (int'(iter_q) + 1) == int'(cur_s_q);
  assign wrap      = int'(pos_q) == (PE_NB - 1);

  fios_pend_slot #(.SW(SW)) u_pend (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .load    (load),
    .s_new   (bus.s_i),
    .pop     (pop),
    .ready   (pend_ready),
    .s_held  (held_s)
  );

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    pos_d   = pos_q;
    gap_d   = gap_q;
    cur_s_d = cur_s_q;
    if (gap_q != '0) gap_d = gap_q - 1'b1;
    unique case (state_q)
      IDLE: state_d = IDLE;
      ISSUE: begin
        if (issue_now && last_iter) begin
          if (RES_OFFSET > 1) begin
            state_d = DRAIN;
            gap_d   = GW'(DRAIN_GAP);
          end else begin
            state_d = PUSH;
            gap_d   = GW'(cur_s_q - 1'b1);
          end
        end else if (issue_now) begin
          iter_d = iter_q + 1'b1;
          pos_d  = wrap ? '0 : pos_q + 1'b1;
          gap_d  = wrap ? GW'(WRAP_GAP) : GW'(STEP_GAP);
        end
      end
      DRAIN: begin
        if (gap_q == '0) begin
          state_d = PUSH;
          gap_d   = GW'(cur_s_q - 1'b1);
        end
      end
      PUSH: if (gap_q == '0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Launch only fires from IDLE or DONE.
    if (launch) begin
      state_d = ISSUE;
      iter_d  = '0;
      pos_d   = '0;
      gap_d   = '0;
      cur_s_d = launch_s;
    end
  end

  assign issue_d = (state_d == ISSUE) && (gap_d == '0);
  assign pe_d    = issue_d ? (PE_ONE << pos_d) : '0;
  assign ash_d   = issue_now && wrap && !last_iter;
  assign fb_d    = (issue_d && (int'(iter_d) == PE_NB))
                || (fb_q && (state_q != DONE));
  assign bcnt_d  = launch ? launch_s
                 : (bcnt_q != '0) ? bcnt_q - 1'b1 : bcnt_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      iter_q  <= '0;
      pos_q   <= '0;
      gap_q   <= '0;
      cur_s_q <= '0;
      bcnt_q  <= '0;
      pe_q    <= '0;
      busy_q  <= 1'b0;
      fb_q    <= 1'b0;
      ash_q   <= 1'b0;
      bf_q    <= 1'b0;
      pf_q    <= 1'b0;
      push_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      pos_q   <= pos_d;
      gap_q   <= gap_d;
      cur_s_q <= cur_s_d;
      bcnt_q  <= bcnt_d;
      pe_q    <= pe_d;
      busy_q  <= state_d != IDLE;
      fb_q    <= fb_d;
      ash_q   <= ash_d;
      bf_q    <= bcnt_d != '0;
      pf_q    <= bf_q;
      push_q  <= state_d == PUSH;
      done_q  <= state_d == DONE;
    end
  end

  assign bus.start_ready_o = pend_ready;
  assign bus.busy_o        = busy_q;
  assign bus.pe_start_o    = pe_q;
  assign bus.fb_sel_o      = fb_q;
  assign bus.a_shift_o     = ash_q;
  assign bus.b_fetch_o     = bf_q;
  assign bus.p_fetch_o     = pf_q;
  assign bus.res_push_o    = push_q;
  assign bus.done_o        = done_q;

endmodule
